instruction_fetch: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. Holds the program counter, issues word reads to instruction memory through a ready handshake, and writes the IF/ID pipeline register: instruction plus PC+4. The instruction-decode stage samples that register on the falling edge. Stall requests come from hazard detection (`pcWrite`, `ifIdWrite`) and redirects come from branch resolution; both are honoured without losing or duplicating an instruction.

---
 rtl/instruction_fetch.sv | 130 +++++++++++++
 tb/tb_instruction_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC, ready-handshake imem reads, IF/ID register (PC+4, instruction).
// Define FETCH_STATS_EN to build the fetchCount/bubbleCount statistics counters.
module instruction_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcWrite,
   input  logic        ifIdWrite,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   output logic        imemRead,
   output logic [31:0] imemAddress,
   input  logic        imemReady,
   input  logic [31:0] imemData,
   output logic [31:0] programCounterOut,
   output logic [31:0] instruction,
   output logic [31:0] fetchCount,
   output logic [31:0] bubbleCount
);

   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] pcOut_q, pcOut_d;
   logic [31:0] instr_q, instr_d;
   logic        fetchInc, bubbleInc;
   logic        stall;
   logic [31:0] target;

   assign stall       = !pcWrite || !ifIdWrite;
   assign target      = {branchTarget[31:2], 2'b00};
   assign imemRead    = (state_q == FETCH);
   assign imemAddress = pc_q;

   assign programCounterOut = pcOut_q;
   assign instruction       = instr_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      hold_d    = hold_q;
      pcOut_d   = pcOut_q;
      instr_d   = instr_q;
      fetchInc  = 1'b0;
      bubbleInc = 1'b0;
      if (branchTaken) begin
         // Redirect wins over stall and any transfer completing on this edge.
         pc_d      = target;
         pcOut_d   = target + 32'd4;
         instr_d   = NOP_WORD;
         hold_d    = '0;
         state_d   = FETCH;
         bubbleInc = 1'b1;
      end else begin
         case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
               if (imemReady && !stall) begin
                  pcOut_d  = pc_q + 32'd4;
                  instr_d  = imemData;
                  pc_d     = pc_q + 32'd4;
                  fetchInc = 1'b1;
               end else if (imemReady) begin
                  hold_d  = imemData;
                  state_d = HOLD;
               end else if (!stall) begin
                  pcOut_d   = pc_q + 32'd4;
                  instr_d   = NOP_WORD;
                  bubbleInc = 1'b1;
               end
            end
            HOLD: begin
               if (!stall) begin
                  pcOut_d  = pc_q + 32'd4;
                  instr_d  = hold_q;
                  pc_d     = pc_q + 32'd4;
                  state_d  = FETCH;
                  fetchInc = 1'b1;
               end
            end
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         hold_q  <= '0;
         pcOut_q <= RESET_VECTOR + 32'd4;
         instr_q <= NOP_WORD;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         pcOut_q <= pcOut_d;
         instr_q <= instr_d;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] fetchCnt_q, bubbleCnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetchCnt_q  <= '0;
         bubbleCnt_q <= '0;
      end else begin
         if (fetchInc)  fetchCnt_q  <= fetchCnt_q + 32'd1;
         if (bubbleInc) bubbleCnt_q <= bubbleCnt_q + 32'd1;
      end
   end

   assign fetchCount  = fetchCnt_q;
   assign bubbleCount = bubbleCnt_q;
`else
   logic unusedInc;
   assign unusedInc   = fetchInc ^ bubbleInc;
   assign fetchCount  = '0;
   assign bubbleCount = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: memory words are address ^ 32'hC0DE_0000.
module tb_instruction_fetch;

   localparam logic [31:0] RV  = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pcWrite = 1'b1, ifIdWrite = 1'b1, branchTaken = 1'b0;
   logic [31:0] branchTarget = '0;
   logic        imemRead, imemReady = 1'b1;
   logic [31:0] imemAddress, imemData;
   logic [31:0] programCounterOut, instruction, fetchCount, bubbleCount;

   instruction_fetch #(.RESET_VECTOR(RV), .NOP_WORD(NOP)) dut (
      .clk(clk), .reset(reset), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
      .branchTaken(branchTaken), .branchTarget(branchTarget),
      .imemRead(imemRead), .imemAddress(imemAddress), .imemReady(imemReady),
      .imemData(imemData), .programCounterOut(programCounterOut),
      .instruction(instruction), .fetchCount(fetchCount), .bubbleCount(bubbleCount)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign imemData = imemReady ? m(imemAddress) : 32'hDEAD_BEEF;

   typedef struct packed {
      logic rdy, pw, iw, br;
      logic [31:0] tgt;
      logic wr;
      logic [31:0] pc4, ins;
   } row_t;

   typedef struct packed { logic [31:0] pc4, ins; } ent_t;

   ent_t        sb[$];
   ent_t        last;
   int unsigned errors = 0, checks = 0;
   int unsigned exp_fetch = 0, exp_bub = 0;

   function automatic row_t R(input logic rdy, pw, iw, br, input logic [31:0] tgt,
                              input logic wr, input logic [31:0] pc4, ins);
      return '{rdy, pw, iw, br, tgt, wr, pc4, ins};
   endfunction

   // Drives one cycle of stimulus, queues the IF/ID entry it should produce, and steps past the edge.
   task automatic drive(input row_t r);
      imemReady = r.rdy; pcWrite = r.pw; ifIdWrite = r.iw;
      branchTaken = r.br; branchTarget = r.tgt;
      if (r.wr) begin
         sb.push_back('{r.pc4, r.ins});
         if (r.ins === NOP) exp_bub++; else exp_fetch++;
      end
      @(posedge clk); #1;
      branchTaken = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({imemRead, imemAddress, programCounterOut, instruction} !== {1'b0, RV, RV + 32'd4, NOP}) begin
         errors++;
         $display("FAIL reset: rd/addr/pc4/ins got %b/%h/%h/%h need 0/%h/%h/%h",
                  imemRead, imemAddress, programCounterOut, instruction, RV, RV + 32'd4, NOP);
      end
      checks++;
      if ({fetchCount, bubbleCount} !== 64'd0) begin
         errors++;
         $display("FAIL reset_counts: got %0d/%0d need 0/0", fetchCount, bubbleCount);
      end
      last = '{RV + 32'd4, NOP};
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_sequential;
      row_t rows[3];
      rows[0] = R(1, 1, 1, 0, '0, 0, 0, 0);
      rows[1] = R(1, 1, 1, 0, '0, 1, 32'h104, m(32'h100));
      rows[2] = R(1, 1, 1, 0, '0, 1, 32'h108, m(32'h104));
      for (int i = 0; i < 3; i++) begin
         drive(rows[i]);
         if (rows[i].wr) last = sb.pop_front();
         checks++;
         if ({programCounterOut, instruction} !== {last.pc4, last.ins}) begin
            errors++;
            $display("FAIL seq[%0d]: ifid got %h/%h need %h/%h", i, programCounterOut, instruction, last.pc4, last.ins);
         end
         if (i == 0) begin
            checks++;
            if ({imemRead, imemAddress} !== {1'b1, RV}) begin
               errors++;
               $display("FAIL boot_exit: rd/addr got %b/%h need 1/%h", imemRead, imemAddress, RV);
            end
         end
      end
   endtask

   task automatic test_wait_states;
      row_t rows[3];
      rows[0] = R(0, 1, 1, 0, '0, 1, 32'h10C, NOP);
      rows[1] = R(0, 1, 1, 0, '0, 1, 32'h10C, NOP);
      rows[2] = R(1, 1, 1, 0, '0, 1, 32'h10C, m(32'h108));
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imemAddress !== 32'h108) begin
            errors++;
            $display("FAIL wait_pc[%0d]: addr got %h need 00000108", i, imemAddress);
         end
         drive(rows[i]);
         if (rows[i].wr) last = sb.pop_front();
         checks++;
         if ({programCounterOut, instruction} !== {last.pc4, last.ins}) begin
            errors++;
            $display("FAIL wait[%0d]: ifid got %h/%h need %h/%h", i, programCounterOut, instruction, last.pc4, last.ins);
         end
      end
   endtask

   task automatic test_stall;
      row_t rows[5];
      rows[0] = R(1, 0, 0, 0, '0, 0, 0, 0);
      rows[1] = R(1, 0, 1, 0, '0, 0, 0, 0);
      rows[2] = R(0, 1, 0, 0, '0, 0, 0, 0);
      rows[3] = R(1, 1, 1, 0, '0, 1, 32'h110, m(32'h10C));
      rows[4] = R(1, 1, 1, 0, '0, 1, 32'h114, m(32'h110));
      for (int i = 0; i < 5; i++) begin
         drive(rows[i]);
         if (rows[i].wr) last = sb.pop_front();
         checks++;
         if ({programCounterOut, instruction} !== {last.pc4, last.ins}) begin
            errors++;
            $display("FAIL stall[%0d]: ifid got %h/%h need %h/%h", i, programCounterOut, instruction, last.pc4, last.ins);
         end
         if (i < 3) begin
            checks++;
            if (imemRead !== 1'b0) begin
               errors++;
               $display("FAIL stall_rd[%0d]: imemRead got %b need 0", i, imemRead);
            end
         end
      end
   endtask

   task automatic test_branch;
      row_t rows[5];
      rows[0] = R(1, 0, 0, 0, '0, 0, 0, 0);
      rows[1] = R(0, 0, 0, 1, 32'h2003, 1, 32'h2004, NOP);
      rows[2] = R(1, 1, 1, 0, '0, 1, 32'h2004, m(32'h2000));
      rows[3] = R(1, 1, 1, 1, 32'h3000, 1, 32'h3004, NOP);
      rows[4] = R(1, 1, 1, 0, '0, 1, 32'h3004, m(32'h3000));
      for (int i = 0; i < 5; i++) begin
         drive(rows[i]);
         if (rows[i].wr) last = sb.pop_front();
         checks++;
         if ({programCounterOut, instruction} !== {last.pc4, last.ins}) begin
            errors++;
            $display("FAIL branch[%0d]: ifid got %h/%h need %h/%h", i, programCounterOut, instruction, last.pc4, last.ins);
         end
         if (i == 1) begin
            checks++;
            if ({imemRead, imemAddress} !== {1'b1, 32'h2000}) begin
               errors++;
               $display("FAIL branch_pc: rd/addr got %b/%h need 1/00002000", imemRead, imemAddress);
            end
         end
      end
   endtask

   task automatic test_wrap;
      row_t rows[3];
      rows[0] = R(1, 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h0, NOP);
      rows[1] = R(1, 1, 1, 0, '0, 1, 32'h0, m(32'hFFFF_FFFC));
      rows[2] = R(1, 1, 1, 0, '0, 1, 32'h4, m(32'h0));
      for (int i = 0; i < 3; i++) begin
         drive(rows[i]);
         if (rows[i].wr) last = sb.pop_front();
         checks++;
         if ({programCounterOut, instruction} !== {last.pc4, last.ins}) begin
            errors++;
            $display("FAIL wrap[%0d]: ifid got %h/%h need %h/%h", i, programCounterOut, instruction, last.pc4, last.ins);
         end
         if (i == 1) begin
            checks++;
            if (imemAddress !== 32'h0) begin
               errors++;
               $display("FAIL wrap_pc: addr got %h need 00000000", imemAddress);
            end
         end
      end
   endtask

   task automatic test_counters;
      logic [31:0] ef, eb;
`ifdef FETCH_STATS_EN
      ef = exp_fetch; eb = exp_bub;
`else
      ef = '0; eb = '0;
`endif
      checks++;
      if ({fetchCount, bubbleCount} !== {ef, eb}) begin
         errors++;
         $display("FAIL counters: fetch/bubble got %0d/%0d need %0d/%0d", fetchCount, bubbleCount, ef, eb);
      end
   endtask

   task automatic test_async_reset;
      row_t rows[2];
      checks++;
      if (imemRead !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_rd: imemRead got %b need 1", imemRead);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({imemRead, imemAddress, programCounterOut, instruction, fetchCount, bubbleCount}
          !== {1'b0, RV, RV + 32'd4, NOP, 64'd0}) begin
         errors++;
         $display("FAIL async_reset: rd/addr/pc4/ins/fc/bc got %b/%h/%h/%h/%0d/%0d need 0/%h/%h/%h/0/0",
                  imemRead, imemAddress, programCounterOut, instruction, fetchCount, bubbleCount,
                  RV, RV + 32'd4, NOP);
      end
      sb.delete();
      exp_fetch = 0; exp_bub = 0;
      last = '{RV + 32'd4, NOP};
      @(negedge clk);
      reset = 1'b0;
      rows[0] = R(1, 1, 1, 0, '0, 0, 0, 0);
      rows[1] = R(1, 1, 1, 0, '0, 1, 32'h104, m(32'h100));
      for (int i = 0; i < 2; i++) begin
         drive(rows[i]);
         if (rows[i].wr) last = sb.pop_front();
         checks++;
         if ({programCounterOut, instruction} !== {last.pc4, last.ins}) begin
            errors++;
            $display("FAIL rerun[%0d]: ifid got %h/%h need %h/%h", i, programCounterOut, instruction, last.pc4, last.ins);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_states();
      test_counters();
      test_stall();
      test_branch();
      test_wrap();
      test_counters();
      test_async_reset();
      test_counters();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
